axi_master_rd_split: RTL and testbench
======================================

# axi_master_rd_split

Parametrised AXI4 read master for the accelerator datapath. Accepts one local read request of up to 65535 beats and splits it into AXI bursts. No burst exceeds MAX_BURST beats or crosses a 4 KB boundary. Up to MAX_OUTSTANDING bursts may be in flight. AR issue is credit-gated against the internal read FIFO, so rready never back-pressures the slave. Returned data streams to the local side with a last-beat marker for each request.

## Interface
- ID_WIDTH, 2, arid width; arid is tied to 0.
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 512, data width (power of 2, 32..1024). BPB = DATA_WIDTH/8. arsize = log2(BPB).
- ARUSER_WIDTH, 8, aruser = i_snap_context[ARUSER_WIDTH-1:0].
- MAX_BURST, 64, beats per burst, 1..256, power of 2.
- MAX_OUTSTANDING, 8, maximum ARs in flight, power of 2, ≥2.
- FIFO_DEPTH, 256, read FIFO entries, power of 2, ≥MAX_BURST.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous soft reset (deferred, see Operation).
- i_snap_context  in  32  context; low bits drive aruser.
- m_axi_ar*  AXI4 AR channel: arid, araddr, arlen[7:0], arsize[2:0], arburst[1:0]=INCR, aruser, arcache=4'd3, arlock=0, arprot=0, arqos=0, arregion=0, arvalid out / arready in.
- m_axi_r*  AXI4 R channel: rready out; rid, rdata, rresp[1:0], rlast, rvalid in.
- lcl_req_valid  in  1  request strobe.
- lcl_req_ready  out  1  high only in IDLE.
- lcl_req_addr  in  ADDR_WIDTH  start byte address; low log2(BPB) bits forced to 0.
- lcl_req_beats  in  16  beat count; 0 = no-op.
- lcl_ordy  out  1  FIFO non-empty.
- lcl_rden  in  1  pop request.
- lcl_dv  out  1  data valid, one cycle after accepted lcl_rden.
- lcl_dout  out  DATA_WIDTH  popped data.
- lcl_dlast  out  1  qualified by lcl_dv: final beat of a request.
- status  out  8  [7] busy, [6] fifo empty, [5] udfl, [4] unexpected rvalid, [3:2] sticky rresp, [1:0] 0.

## Operation
- FSM states: IDLE, CALC, ISSUE.
  - IDLE: on lcl_req_valid with lcl_req_beats≠0, latch addr and remaining=beats, go to CALC. With beats=0, accept and stay in IDLE.
  - CALC: len = min(remaining, MAX_BURST, (4096-addr[11:0])/BPB). Register len, go to ISSUE.
  - ISSUE: assert arvalid when both hold: outstanding<MAX_OUTSTANDING and FIFO_DEPTH-reserved ≥ len. araddr, arlen=len-1 and arvalid hold until arready.
  - On AR handshake: addr += len*BPB, remaining -= len, reserved += len, outstanding++, push final flag (remaining==len) into a MAX_OUTSTANDING-deep flag queue. Go to CALC if remaining≠0, else IDLE.
- The next request may be accepted while earlier bursts are still in flight. Ordering is preserved because all bursts use ID 0.
- rready is 1 from the first cycle after reset.
- R handshake is registered into the FIFO one cycle later. On rlast: outstanding--, pop the flag queue. The FIFO last bit = rlast AND popped flag.
- reserved: incremented by len on AR handshake, decremented by 1 on each lcl_dv. Same-cycle events apply net.
- lcl_rden while empty is ignored: no lcl_dv, status[5] set.
- rvalid with outstanding==0: data dropped, status[4] set.
- Sticky rresp: records the first nonzero rresp.
- clear is honoured only when arvalid=0 and outstanding=0; otherwise it is held pending until both are true. Once honoured, it resets FSM, FIFO, counters, flags and sticky errors.
- busy = state≠IDLE or outstanding≠0 or FIFO non-empty.

## Timing
- Reset values: arvalid 0, araddr 0, arlen 0, rready 0, lcl_req_ready 1, lcl_ordy 0, lcl_dv 0, lcl_dout 0, lcl_dlast 0, status 8'h40.
- Request accept to first arvalid: 2 cycles with credit available.
- Between bursts: ≥2 cycles from AR handshake to next arvalid (via CALC).
- rvalid&rready to lcl_ordy: 2 cycles. lcl_rden to lcl_dv: 1 cycle.
- Credit rule: the FIFO can never overflow. An overflow is a design bug and is asserted in simulation.

## Test plan
- DATA_WIDTH=512, addr 0x0, beats 16 → one AR with arlen=15. 16 beats delivered; lcl_dlast only on beat 16.
- addr 0xF80, beats 8 → AR 0xF80 len 2 (arlen=1), then AR 0x1000 len 6 (arlen=5). Exactly one lcl_dlast.
- beats 200, MAX_BURST 64, addr 0 → ARs with lengths 64,64,64,8 at addresses 0x0, 0x1000, 0x2000, 0x3000.
- FIFO_DEPTH 128, lcl_rden held 0, beats 256 → two 64-beat ARs, then arvalid stays 0. After 64 pops the third AR issues. rready never drops.
- Back-to-back requests of 3 and 5 beats from addr 0x0 → lcl_dlast on beats 3 and 8. outstanding peaks at 2. An rresp=2'b10 on beat 4 → status[3:2]=2'b10, stays until clear.
- clear asserted with 1 burst outstanding → deferred until rlast. Then status returns to 8'h40. Assert rst_n low mid-burst → all outputs at reset values immediately.

Source files
------------

// File: rtl/axi_master_rd_split.sv
// AXI4 read master: splits one local read request into INCR bursts
// (<=MAX_BURST beats, no 4 KB crossing) and streams data out of a FIFO.
// Ports: clk/rst_n/clear, i_snap_context, m_axi_ar*/m_axi_r*, lcl_req_*,
// lcl_ordy/lcl_rden/lcl_dv/lcl_dout/lcl_dlast, status.
module axi_master_rd_split #(
  parameter int ID_WIDTH        = 2,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int ARUSER_WIDTH    = 8,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 8,
  parameter int FIFO_DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [31:0]             i_snap_context,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic [3:0]              m_axi_arcache,
  output logic                    m_axi_arlock,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic                    m_axi_rready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  input  logic                    lcl_req_valid,
  output logic                    lcl_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lcl_req_addr,
  input  logic [15:0]             lcl_req_beats,
  output logic                    lcl_ordy,
  input  logic                    lcl_rden,
  output logic                    lcl_dv,
  output logic [DATA_WIDTH-1:0]   lcl_dout,
  output logic                    lcl_dlast,
  output logic [7:0]              status
);
  localparam int LB = $clog2(DATA_WIDTH / 8);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int QW = $clog2(MAX_OUTSTANDING);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int RW = FW + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE} st_t;

  st_t                   r_st;
  logic [ADDR_WIDTH-1:0] r_addr, r_araddr;
  logic [15:0]           r_rem;
  logic [8:0]            r_len;
  logic [7:0]            r_arlen;
  logic                  r_arvalid, r_rready, r_clr_pend;
  logic [OW-1:0]         r_outst;
  logic [RW-1:0]         r_resv;
  logic                  r_flag [MAX_OUTSTANDING];
  logic [QW-1:0]         r_fwp, r_frp;
  logic                  r_sv, r_slast;
  logic [DATA_WIDTH-1:0] r_sdata;
  logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [FW:0]           r_wp, r_rp;
  logic                  r_dv, r_dlast;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_udfl, r_unexp;
  logic [1:0]            r_resp;

  logic [12:0]   w_pg;
  logic [16:0]   w_m1, w_min;
  logic [RW-1:0] w_free;
  logic          w_credit, w_fin, w_arhs, w_racc, w_rdone;
  logic          w_empty, w_full, w_push, w_pop, w_clr, w_busy;
  logic          w_unused;

  // Beats left before the next 4 KB page boundary.
  assign w_pg  = (13'h1000 - {1'b0, r_addr[11:0]}) >> LB;
  assign w_m1  = ({1'b0, r_rem} < 17'(MAX_BURST)) ?
                 {1'b0, r_rem} : 17'(MAX_BURST);
  assign w_min = (w_m1 < {4'b0, w_pg}) ? w_m1 : {4'b0, w_pg};

  assign w_free   = RW'(FIFO_DEPTH) - r_resv;
  assign w_credit = (r_outst < OW'(MAX_OUTSTANDING)) &&
                    (32'(w_free) >= 32'(r_len));
  assign w_fin    = (r_rem == 16'(r_len));
  assign w_arhs   = r_arvalid & m_axi_arready;
  assign w_racc   = m_axi_rvalid & r_rready & (r_outst != '0);
  assign w_rdone  = r_sv & r_slast;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[FW] != r_rp[FW]) &&
                   (r_wp[FW-1:0] == r_rp[FW-1:0]);
  assign w_push  = r_sv;
  assign w_pop   = lcl_rden & ~w_empty;

  // Soft reset waits until no AR is pending and no burst is in flight.
  assign w_clr  = (clear | r_clr_pend) & ~r_arvalid & (r_outst == '0);
  assign w_busy = (r_st != S_IDLE) | (r_outst != '0) | ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= S_IDLE;
      r_addr    <= '0;
      r_rem     <= '0;
      r_len     <= '0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
    end else if (w_clr) begin
      r_st      <= S_IDLE;
      r_rem     <= '0;
      r_len     <= '0;
      r_arvalid <= 1'b0;
    end else begin
      unique case (r_st)
        S_IDLE: begin
          if (lcl_req_valid && lcl_req_ready &&
              lcl_req_beats != 16'd0) begin
            r_addr <= {lcl_req_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
            r_rem  <= lcl_req_beats;
            r_st   <= S_CALC;
          end
        end
        S_CALC: begin
          r_len <= w_min[8:0];
          r_st  <= S_ISSUE;
        end
        S_ISSUE: begin
          if (w_arhs) begin
            r_arvalid <= 1'b0;
            r_addr    <= r_addr + (ADDR_WIDTH'(r_len) << LB);
            r_rem     <= r_rem - 16'(r_len);
            r_st      <= w_fin ? S_IDLE : S_CALC;
          end else if (!r_arvalid && w_credit) begin
            r_arvalid <= 1'b1;
            r_araddr  <= r_addr;
            r_arlen   <= 8'(r_len - 9'd1);
          end
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rready   <= 1'b0;
      r_clr_pend <= 1'b0;
      r_outst    <= '0;
      r_resv     <= '0;
      r_fwp      <= '0;
      r_frp      <= '0;
    end else begin
      r_rready <= 1'b1;
      if (w_clr) begin
        r_clr_pend <= 1'b0;
        r_outst    <= '0;
        r_resv     <= '0;
        r_fwp      <= '0;
        r_frp      <= '0;
      end else begin
        if (clear) r_clr_pend <= 1'b1;
        r_outst <= r_outst + OW'(w_arhs) - OW'(w_rdone);
        r_resv  <= r_resv + (w_arhs ? RW'(r_len) : '0) - RW'(r_dv);
        if (w_arhs)  r_fwp <= r_fwp + 1'b1;
        if (w_rdone) r_frp <= r_frp + 1'b1;
      end
    end
  end

  // Per-burst "last burst of request" flags, consumed in AR order.
  always_ff @(posedge clk) begin
    if (w_arhs) r_flag[r_fwp] <= w_fin;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wp[FW-1:0]] <= {r_slast & r_flag[r_frp], r_sdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sv    <= 1'b0;
      r_slast <= 1'b0;
      r_sdata <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_dv    <= 1'b0;
      r_dout  <= '0;
      r_dlast <= 1'b0;
      r_udfl  <= 1'b0;
      r_unexp <= 1'b0;
      r_resp  <= 2'b00;
    end else if (w_clr) begin
      r_sv    <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_dv    <= 1'b0;
      r_dout  <= '0;
      r_dlast <= 1'b0;
      r_udfl  <= 1'b0;
      r_unexp <= 1'b0;
      r_resp  <= 2'b00;
    end else begin
      r_sv    <= w_racc;
      r_slast <= m_axi_rlast;
      r_sdata <= m_axi_rdata;
      if (w_push) r_wp <= r_wp + 1'b1;
      r_dv <= w_pop;
      if (w_pop) begin
        r_rp    <= r_rp + 1'b1;
        r_dout  <= r_mem[r_rp[FW-1:0]][DATA_WIDTH-1:0];
        r_dlast <= r_mem[r_rp[FW-1:0]][DATA_WIDTH];
      end
      if (lcl_rden && w_empty) r_udfl <= 1'b1;
      if (m_axi_rvalid && r_rready && r_outst == '0) r_unexp <= 1'b1;
      if (w_racc && r_resp == 2'b00) r_resp <= m_axi_rresp;
    end
  end

  overflow_a : assert property (
    @(posedge clk) disable iff (!rst_n) !(w_push && w_full));

  assign m_axi_arid     = '0;
  assign m_axi_araddr   = r_araddr;
  assign m_axi_arlen    = r_arlen;
  assign m_axi_arsize   = 3'(LB);
  assign m_axi_arburst  = 2'b01;
  assign m_axi_aruser   = i_snap_context[ARUSER_WIDTH-1:0];
  assign m_axi_arcache  = 4'd3;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arprot   = 3'd0;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;
  assign m_axi_arvalid  = r_arvalid;
  assign m_axi_rready   = r_rready;
  assign lcl_req_ready  = (r_st == S_IDLE) & ~r_clr_pend;
  assign lcl_ordy       = ~w_empty;
  assign lcl_dv         = r_dv;
  assign lcl_dout       = r_dout;
  assign lcl_dlast      = r_dlast;
  assign status = {w_busy, w_empty, r_udfl, r_unexp, r_resp, 2'b00};

  assign w_unused = ^{m_axi_rid, lcl_req_addr[LB-1:0],
                      w_min[16:9], i_snap_context};
endmodule

// File: tb/tb_axi_master_rd_split.sv
// Directed bench for axi_master_rd_split: vector table of requests
// plus sequences for credit stall, back-to-back, errors, clear, reset.
module tb_axi_master_rd_split;
  localparam int DW = 512;
  localparam int AW = 64;

  logic          clk = 0;
  logic          rst_n, clear;
  logic [31:0]   i_snap_context;
  logic [1:0]    m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic [7:0]    m_axi_aruser;
  logic [3:0]    m_axi_arcache;
  logic          m_axi_arlock;
  logic [2:0]    m_axi_arprot;
  logic [3:0]    m_axi_arqos;
  logic [3:0]    m_axi_arregion;
  logic          m_axi_arvalid, m_axi_arready, m_axi_rready;
  logic [1:0]    m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid;
  logic          lcl_req_valid, lcl_req_ready;
  logic [AW-1:0] lcl_req_addr;
  logic [15:0]   lcl_req_beats;
  logic          lcl_ordy, lcl_rden, lcl_dv, lcl_dlast;
  logic [DW-1:0] lcl_dout;
  logic [7:0]    status;

  axi_master_rd_split #(
    .ID_WIDTH(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ARUSER_WIDTH(8), .MAX_BURST(64), .MAX_OUTSTANDING(8),
    .FIFO_DEPTH(128)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .i_snap_context(i_snap_context),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_aruser(m_axi_aruser),
    .m_axi_arcache(m_axi_arcache), .m_axi_arlock(m_axi_arlock),
    .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rready(m_axi_rready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid),
    .lcl_req_valid(lcl_req_valid), .lcl_req_ready(lcl_req_ready),
    .lcl_req_addr(lcl_req_addr), .lcl_req_beats(lcl_req_beats),
    .lcl_ordy(lcl_ordy), .lcl_rden(lcl_rden), .lcl_dv(lcl_dv),
    .lcl_dout(lcl_dout), .lcl_dlast(lcl_dlast), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    l;
  } ar_t;

  typedef struct {
    logic [AW-1:0]       addr;
    logic [15:0]         beats;
    int                  nar;
    logic [3:0][AW-1:0]  aa;
    logic [3:0][7:0]     al;
  } vec_t;

  vec_t v [6];

  int  n_chk = 0, n_pass = 0;
  int  cyc = 0, first_rise = -1, acc_cyc = 0;
  int  pop_left = 0, beat_k = 0, r_beat_no = 0, err_beat = -1;
  bit  r_hold = 0, bogus_r = 0, force_rd = 0;
  bit  rr_mon = 0, rr_drop = 0, prev_arv = 0, ar_hs, r_hs;
  ar_t arq [$];
  ar_t ar_log [$];
  ar_t e;
  logic [DW-1:0] rx_d [$];
  bit            rx_l [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // AXI slave model, local-side collector and monitors.
  initial begin
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      if (rr_mon && !m_axi_rready) rr_drop = 1;
      if (m_axi_arvalid && !prev_arv && first_rise < 0)
        first_rise = cyc;
      prev_arv = m_axi_arvalid;
      if (lcl_dv) begin
        rx_d.push_back(lcl_dout);
        rx_l.push_back(lcl_dlast);
      end
      @(posedge clk); #1;
      if (!rst_n) begin
        arq.delete();
        beat_k = 0;
        m_axi_rvalid = 0;
      end else begin
        if (ar_hs) begin
          e.a = m_axi_araddr;
          e.l = m_axi_arlen;
          arq.push_back(e);
          ar_log.push_back(e);
        end
        if (r_hs && arq.size() > 0) begin
          r_beat_no++;
          if (beat_k == int'(arq[0].l)) begin
            void'(arq.pop_front());
            beat_k = 0;
          end else beat_k++;
        end
        if (!r_hold && arq.size() > 0) begin
          m_axi_rvalid = 1;
          m_axi_rdata = '0;
          m_axi_rdata[63:0] = arq[0].a + 64'(beat_k * 64);
          m_axi_rlast = (beat_k == int'(arq[0].l));
          m_axi_rresp = (r_beat_no == err_beat) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = bogus_r;
          m_axi_rlast = 1;
          m_axi_rdata = '0;
          m_axi_rresp = 2'b00;
          bogus_r = 0;
        end
      end
    end
  end

  initial begin
    lcl_rden = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) lcl_rden = 0;
      else if (force_rd) lcl_rden = 1;
      else if (pop_left > 0 && lcl_ordy) begin
        lcl_rden = 1;
        pop_left--;
      end else lcl_rden = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic set_vec(input int i, input logic [AW-1:0] a,
      input logic [15:0] b, input int n,
      input logic [AW-1:0] a0, input logic [7:0] l0,
      input logic [AW-1:0] a1, input logic [7:0] l1,
      input logic [AW-1:0] a2, input logic [7:0] l2,
      input logic [AW-1:0] a3, input logic [7:0] l3);
    v[i].addr = a; v[i].beats = b; v[i].nar = n;
    v[i].aa[0] = a0; v[i].al[0] = l0;
    v[i].aa[1] = a1; v[i].al[1] = l1;
    v[i].aa[2] = a2; v[i].al[2] = l2;
    v[i].aa[3] = a3; v[i].al[3] = l3;
  endtask

  task automatic req(input logic [AW-1:0] a, input logic [15:0] b);
    bit got = 0;
    @(posedge clk); #1;
    lcl_req_valid = 1;
    lcl_req_addr  = a;
    lcl_req_beats = b;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (lcl_req_ready) begin
        got = 1;
        acc_cyc = cyc + 1;
      end
    end
    if (!got) chk("req_accept", 0, 1);
    @(posedge clk); #1;
    lcl_req_valid = 0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string nm);
    for (int k = 0; k < budget && rx_d.size() < n; k++) @(negedge clk);
    chk(nm, rx_d.size(), n);
  endtask

  task automatic wait_ar(input int n, input int budget, input string nm);
    for (int k = 0; k < budget && ar_log.size() < n; k++) @(negedge clk);
    chk(nm, ar_log.size(), n);
  endtask

  function automatic int data_errs(input logic [AW-1:0] base,
                                   input int from, input int n);
    int errs = 0;
    logic [DW-1:0] ex;
    for (int i = 0; i < n; i++) begin
      ex = '0;
      ex[63:0] = base + 64'(i * 64);
      if (from + i >= rx_d.size() || rx_d[from + i] !== ex) errs++;
    end
    return errs;
  endfunction

  task automatic run_vec(input int i);
    int nl = 0;
    bit lastok;
    @(negedge clk);
    ar_log.delete(); rx_d.delete(); rx_l.delete();
    first_rise = -1;
    pop_left = 100000;
    req(v[i].addr, v[i].beats);
    if (v[i].beats == 0) begin
      repeat (10) @(negedge clk);
      chk($sformatf("v%0d_nar", i), ar_log.size(), 0);
      chk($sformatf("v%0d_rx", i), rx_d.size(), 0);
      chk($sformatf("v%0d_ready", i), lcl_req_ready, 1);
      return;
    end
    wait_rx(v[i].beats, 3000, $sformatf("v%0d_beats", i));
    repeat (5) @(negedge clk);
    chk($sformatf("v%0d_lat", i), first_rise - acc_cyc, 2);
    chk($sformatf("v%0d_nar", i), ar_log.size(), v[i].nar);
    for (int j = 0; j < v[i].nar && j < ar_log.size(); j++) begin
      chk($sformatf("v%0d_araddr%0d", i, j), ar_log[j].a, v[i].aa[j]);
      chk($sformatf("v%0d_arlen%0d", i, j), ar_log[j].l, v[i].al[j]);
    end
    chk($sformatf("v%0d_data", i),
        data_errs(v[i].addr & ~64'h3F, 0, v[i].beats), 0);
    foreach (rx_l[k]) if (rx_l[k]) nl++;
    lastok = (rx_l.size() > 0) && rx_l[rx_l.size() - 1];
    chk($sformatf("v%0d_dlast", i), {nl[7:0], 7'd0, lastok},
        {8'd1, 7'd0, 1'b1});
    chk($sformatf("v%0d_status", i), status, 8'h40);
  endtask

  initial begin
    logic [7:0] lp;
    rst_n = 0; clear = 0; i_snap_context = 32'hA5A5_5A3C;
    m_axi_arready = 1; m_axi_rid = 0; m_axi_rdata = '0;
    m_axi_rresp = 0; m_axi_rlast = 0; m_axi_rvalid = 0;
    lcl_req_valid = 0; lcl_req_addr = '0; lcl_req_beats = '0;

    set_vec(0, 64'h0, 16, 1, 64'h0, 15, 0, 0, 0, 0, 0, 0);
    set_vec(1, 64'hF80, 8, 2, 64'hF80, 1, 64'h1000, 5, 0, 0, 0, 0);
    set_vec(2, 64'h0, 200, 4, 64'h0, 63, 64'h1000, 63,
            64'h2000, 63, 64'h3000, 7);
    set_vec(3, 64'h10_0000_0FC0, 1, 1, 64'h10_0000_0FC0, 0,
            0, 0, 0, 0, 0, 0);
    set_vec(4, 64'h123F, 2, 1, 64'h1200, 1, 0, 0, 0, 0, 0, 0);
    set_vec(5, 64'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk); #1;
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_req_ready", lcl_req_ready, 1);
    chk("rst_ordy", lcl_ordy, 0);
    chk("rst_dv", lcl_dv, 0);
    chk("rst_status", status, 8'h40);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rready_after_rst", m_axi_rready, 1);
    chk("arsize", m_axi_arsize, 6);
    chk("aruser", m_axi_aruser, 8'h3C);
    rr_mon = 1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Credit stall: FIFO holds 128 beats, so only two 64-beat bursts.
    @(negedge clk);
    ar_log.delete(); rx_d.delete(); rx_l.delete();
    pop_left = 0;
    req(64'h0, 256);
    repeat (300) @(negedge clk);
    chk("credit_nar2", ar_log.size(), 2);
    chk("credit_arvalid", m_axi_arvalid, 0);
    chk("credit_ordy", lcl_ordy, 1);
    pop_left = 63;
    repeat (100) @(negedge clk);
    chk("credit_63pops", ar_log.size(), 2);
    pop_left = 1;
    wait_ar(3, 20, "credit_64pops");
    pop_left = 100000;
    wait_rx(256, 3000, "credit_beats");
    repeat (5) @(negedge clk);
    chk("credit_nar4", ar_log.size(), 4);
    chk("credit_data", data_errs(64'h0, 0, 256), 0);
    chk("rready_held", rr_drop, 0);

    // Back-to-back requests, response error on the fourth beat.
    @(negedge clk);
    ar_log.delete(); rx_d.delete(); rx_l.delete();
    r_hold = 1; r_beat_no = 0; err_beat = 3;
    req(64'h0, 3);
    req(64'h0, 5);
    wait_ar(2, 50, "b2b_nar");
    @(negedge clk);
    chk("b2b_outstanding", arq.size(), 2);
    r_hold = 0;
    wait_rx(8, 200, "b2b_beats");
    repeat (5) @(negedge clk);
    lp = '0;
    for (int k = 0; k < 8 && k < rx_l.size(); k++) lp[k] = rx_l[k];
    chk("b2b_dlast", lp, 8'b1000_0100);
    chk("b2b_data", data_errs(64'h0, 0, 3) +
        data_errs(64'h0, 3, 5), 0);
    chk("b2b_status", status, 8'h48);
    err_beat = -1;

    // Underflow read and unexpected R beat.
    @(negedge clk); force_rd = 1;
    @(negedge clk); force_rd = 0;
    bogus_r = 1;
    repeat (5) @(negedge clk);
    chk("err_rx", rx_d.size(), 8);
    chk("err_status", status, 8'h78);

    // Deferred clear.
    @(negedge clk);
    ar_log.delete();
    r_hold = 1; pop_left = 0;
    req(64'h2000, 4);
    wait_ar(1, 50, "clr_ar");
    @(posedge clk); #1; clear = 1;
    @(posedge clk); #1; clear = 0;
    repeat (10) @(negedge clk);
    chk("clr_deferred", status, 8'hF8);
    r_hold = 0;
    repeat (20) @(negedge clk);
    chk("clr_done", status, 8'h40);
    chk("clr_ordy", lcl_ordy, 0);

    // Reset in the middle of a burst.
    @(negedge clk);
    ar_log.delete();
    req(64'h5000, 64);
    wait_ar(1, 50, "rst_mid_ar");
    for (int k = 0; k < 50 && !lcl_ordy; k++) @(negedge clk);
    chk("rst_mid_ordy_pre", lcl_ordy, 1);
    pop_left = 4;
    repeat (8) @(negedge clk);
    @(posedge clk); #3;
    rr_mon = 0;
    rst_n = 0;
    #1;
    chk("rstm_arvalid", m_axi_arvalid, 0);
    chk("rstm_araddr", m_axi_araddr, 0);
    chk("rstm_arlen", m_axi_arlen, 0);
    chk("rstm_rready", m_axi_rready, 0);
    chk("rstm_req_ready", lcl_req_ready, 1);
    chk("rstm_ordy", lcl_ordy, 0);
    chk("rstm_dv", lcl_dv, 0);
    chk("rstm_dout", (lcl_dout == '0), 1);
    chk("rstm_dlast", lcl_dlast, 0);
    chk("rstm_status", status, 8'h40);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
